// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: coin denomination codes and values,
// FSM state encoding, and a code-to-value helper.
// Optional build macro used by the design: COIN_INVENTORY_EN.
package vend_pkg;

  // Denomination codes as driven on coin_sel
  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_5    = 2'b10,
    COIN_10   = 2'b11
  } coin_e;

  // Dollar value of each denomination
  localparam logic [7:0] VAL_NONE = 8'd0;
  localparam logic [7:0] VAL_1    = 8'd1;
  localparam logic [7:0] VAL_5    = 8'd5;
  localparam logic [7:0] VAL_10   = 8'd10;

  // Dispenser control states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_REQ    = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  // Map a denomination code to its dollar value
  function automatic logic [7:0] coin_value(input coin_e c);
    logic [7:0] v;
    case (c)
      COIN_1:  v = VAL_1;
      COIN_5:  v = VAL_5;
      COIN_10: v = VAL_10;
      default: v = VAL_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the vending controller / coin hopper (master) and the change
// dispenser (slave). With COIN_INVENTORY_EN the refill pulse is added.
interface change_dispenser_if;

  // controller -> dispenser
  logic       start;
  logic [7:0] paid;
  logic [7:0] price;
  // hopper -> dispenser
  logic       coin_ack;
`ifdef COIN_INVENTORY_EN
  logic       refill;
`endif
  // dispenser -> hopper / display / controller
  logic       coin_req;
  logic [1:0] coin_sel;
  logic [7:0] change_left;
  logic       busy;
  logic       done;
  logic       err_underpay;
  logic       fault;

  modport master (
    output start, paid, price, coin_ack,
`ifdef COIN_INVENTORY_EN
    output refill,
`endif
    input  coin_req, coin_sel, change_left, busy, done, err_underpay, fault
  );

  modport slave (
    input  start, paid, price, coin_ack,
`ifdef COIN_INVENTORY_EN
    input  refill,
`endif
    output coin_req, coin_sel, change_left, busy, done, err_underpay, fault
  );

endinterface

// File: rtl/change_dispenser_denom_picker.sv
// Combinational denomination chooser: largest coin that fits the remaining
// change. With COIN_INVENTORY_EN an empty tube is skipped and the next smaller
// denomination is tried; $1 coins are never exhausted.
module denom_picker
  import vend_pkg::*;
(
  input  logic [7:0] i_change,
`ifdef COIN_INVENTORY_EN
  input  logic       i_empty10,
  input  logic       i_empty5,
`endif
  output coin_e      o_sel,
  output logic       o_zero
);

  logic w_use10;
  logic w_use5;

`ifdef COIN_INVENTORY_EN
  assign w_use10 = (i_change >= VAL_10) && !i_empty10;
  assign w_use5  = (i_change >= VAL_5)  && !i_empty5;
`else
  assign w_use10 = (i_change >= VAL_10);
  assign w_use5  = (i_change >= VAL_5);
`endif

  // Priority pick: $10, then $5, then $1, none when nothing is owed
  always_comb begin
    o_sel  = COIN_NONE;
    o_zero = (i_change == 8'd0);
    if (w_use10) begin
      o_sel = COIN_10;
    end else if (w_use5) begin
      o_sel = COIN_5;
    end else if (i_change >= VAL_1) begin
      o_sel = COIN_1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: on start computes paid - price and pays it out through the
// coin hopper one coin at a time, largest denomination first, with an ack
// timeout that latches a sticky fault and a fixed idle gap between coins.
// Optional build macro: COIN_INVENTORY_EN (refill input, per-tube counters for
// $10 and $5 coins).
module change_dispenser
  import vend_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,  // 1..255 cycles of coin_req before FAULT
  parameter int GAP_CYCLES  = 4     // 1..15 idle cycles between coins
`ifdef COIN_INVENTORY_EN
  ,
  parameter int TUBE10_INIT = 20,
  parameter int TUBE5_INIT  = 20
`endif
) (
  input  logic                 clk,
  input  logic                 reset,   // synchronous, active low
  change_dispenser_if.slave    bus
);

  // Last counter values before the REQ timeout / end of GAP
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e      r_state;
  coin_e       r_coin_sel;
  logic        r_coin_req;
  logic [7:0]  r_change_left;
  logic        r_busy;
  logic        r_done;
  logic        r_err_underpay;
  logic        r_fault;
  logic [7:0]  r_tmo;
  logic [3:0]  r_gap;

  coin_e       w_pick_sel;
  logic        w_pick_zero;

`ifdef COIN_INVENTORY_EN
  localparam logic [7:0] CNT10_INIT = 8'(TUBE10_INIT);
  localparam logic [7:0] CNT5_INIT  = 8'(TUBE5_INIT);

  logic [7:0]  r_cnt10;
  logic [7:0]  r_cnt5;
  logic        w_empty10;
  logic        w_empty5;
  logic        w_coin_taken;

  assign w_empty10    = (r_cnt10 == 8'd0);
  assign w_empty5     = (r_cnt5 == 8'd0);
  assign w_coin_taken = (r_state == S_REQ) && bus.coin_ack;

  // Tube inventory: reload on reset or refill, count down on each acked coin
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt10 <= CNT10_INIT;
      r_cnt5  <= CNT5_INIT;
    end else if (bus.refill) begin
      r_cnt10 <= CNT10_INIT;
      r_cnt5  <= CNT5_INIT;
    end else if (w_coin_taken) begin
      if (r_coin_sel == COIN_10) begin
        r_cnt10 <= r_cnt10 - 8'd1;
      end
      if (r_coin_sel == COIN_5) begin
        r_cnt5 <= r_cnt5 - 8'd1;
      end
    end
  end
`endif

  denom_picker u_picker (
    .i_change  (r_change_left),
`ifdef COIN_INVENTORY_EN
    .i_empty10 (w_empty10),
    .i_empty5  (w_empty5),
`endif
    .o_sel     (w_pick_sel),
    .o_zero    (w_pick_zero)
  );

  // Control FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_coin_sel     <= COIN_NONE;
      r_coin_req     <= 1'b0;
      r_change_left  <= 8'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err_underpay <= 1'b0;
      r_fault        <= 1'b0;
      r_tmo          <= 8'd0;
      r_gap          <= 4'd0;
    end else begin
      // single-cycle pulses default low
      r_done         <= 1'b0;
      r_err_underpay <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.paid >= bus.price) begin
              r_change_left <= bus.paid - bus.price;
              r_busy        <= 1'b1;
              r_state       <= S_SELECT;
            end else begin
              r_err_underpay <= 1'b1;
            end
          end
        end
        S_SELECT: begin
          if (w_pick_zero) begin
            r_done        <= 1'b1;
            r_change_left <= 8'd0;
            r_state       <= S_DONE;
          end else begin
            r_coin_sel <= w_pick_sel;
            r_coin_req <= 1'b1;
            r_tmo      <= 8'd0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.coin_ack) begin
            r_change_left <= r_change_left - coin_value(r_coin_sel);
            r_coin_req    <= 1'b0;
            r_coin_sel    <= COIN_NONE;
            r_gap         <= 4'd0;
            r_state       <= S_GAP;
          end else if (r_tmo == TMO_LAST) begin
            // hopper never answered: keep the undispensed amount visible
            r_coin_req <= 1'b0;
            r_coin_sel <= COIN_NONE;
            r_busy     <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= S_FAULT;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= S_SELECT;
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAULT: begin
          // sticky until reset; start and coin_ack have no effect
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.coin_req     = r_coin_req;
  assign bus.coin_sel     = r_coin_sel;
  assign bus.change_left  = r_change_left;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err_underpay = r_err_underpay;
  assign bus.fault        = r_fault;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. A greedy change-making model
// (with optional tube counts under COIN_INVENTORY_EN) predicts each coin.
module tb_change_dispenser;

  localparam int TB_ACK = 8;
  localparam int TB_GAP = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // model state
  int   plan_q[$];
  int   m_cnt10;
  int   m_cnt5;
  int   m_left;

  change_dispenser_if u_if ();

  change_dispenser #(
    .ACK_TIMEOUT (TB_ACK),
    .GAP_CYCLES  (TB_GAP)
`ifdef COIN_INVENTORY_EN
    ,
    .TUBE10_INIT (1),
    .TUBE5_INIT  (20)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int code_of(input int v);
    if (v == 10) return 3;
    if (v == 5) return 2;
    if (v == 1) return 1;
    return 0;
  endfunction

  // Greedy plan of coins for a given change amount, honouring tube stock
  task automatic build_plan(input int ch);
    int c10;
    int c5;
    int rest;
    plan_q.delete();
    rest = ch;
`ifdef COIN_INVENTORY_EN
    c10 = m_cnt10;
    c5  = m_cnt5;
`else
    c10 = 1000;
    c5  = 1000;
`endif
    while (rest > 0) begin
      if (rest >= 10 && c10 > 0) begin
        plan_q.push_back(10); rest -= 10; c10--;
      end else if (rest >= 5 && c5 > 0) begin
        plan_q.push_back(5); rest -= 5; c5--;
      end else begin
        plan_q.push_back(1); rest -= 1;
      end
    end
  endtask

  task automatic model_reload();
    m_cnt10 = 1;
    m_cnt5  = 20;
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if (u_if.coin_req !== 1'b0 || u_if.coin_sel !== 2'b00 || u_if.change_left !== 8'd0 ||
        u_if.busy !== 1'b0 || u_if.done !== 1'b0 || u_if.err_underpay !== 1'b0 ||
        u_if.fault !== 1'b0) begin
      bad++;
      $display("FAIL %s: got req=%b sel=%b left=%0d busy=%b done=%b err=%b fault=%b want all 0",
               tag, u_if.coin_req, u_if.coin_sel, u_if.change_left, u_if.busy, u_if.done,
               u_if.err_underpay, u_if.fault);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    check_all_zero("reset_state");
    reset = 1'b1;
    model_reload();
    m_left = 0;
    step();
    check_all_zero("idle_after_reset");
    $display("txn reset");
  endtask

  // One full transaction with paid >= price
  task automatic test_dispense(input int paid, input int price, input int max_dly, input bit noise);
    int ch;
    int rem;
    int cnt;
    int d;
    int v;
    int ncoins;
    ch = paid - price;
    build_plan(ch);
    ncoins = plan_q.size();
    rem = ch;
    u_if.start = 1'b1;
    u_if.paid  = 8'(paid);
    u_if.price = 8'(price);
    step();
    u_if.start = 1'b0;
    total++;
    if (u_if.busy !== 1'b1 || u_if.coin_req !== 1'b0 || u_if.change_left !== 8'(ch)) begin
      bad++;
      $display("FAIL latch: got busy=%b req=%b left=%0d want busy=1 req=0 left=%0d",
               u_if.busy, u_if.coin_req, u_if.change_left, ch);
    end
    if (ncoins == 0) begin
      step();
      total++;
      if (u_if.done !== 1'b1 || u_if.coin_req !== 1'b0) begin
        bad++;
        $display("FAIL zero_done: got done=%b req=%b want done=1 req=0", u_if.done, u_if.coin_req);
      end
    end else begin
      for (int i = 0; i < ncoins; i++) begin
        v = plan_q[i];
        cnt = 0;
        while (u_if.coin_req !== 1'b1 && cnt < 20) begin
          if (u_if.done === 1'b1) begin
            bad++; total++;
            $display("FAIL early_done: got done=1 with %0d coins outstanding want 0", ncoins - i);
          end
          step();
          cnt++;
        end
        total++;
        if (u_if.coin_req !== 1'b1) begin
          bad++;
          $display("FAIL req_wait: got coin_req=%b after %0d cycles want 1", u_if.coin_req, cnt);
          return;
        end
        if (i == 0) begin
          total++;
          if (cnt != 1) begin
            bad++;
            $display("FAIL req_latency: got %0d cycles after start edge want 1", cnt);
          end
        end
        total++;
        if (u_if.coin_sel !== 2'(code_of(v)) || u_if.change_left !== 8'(rem)) begin
          bad++;
          $display("FAIL coin%0d: got sel=%b left=%0d want sel=%b left=%0d",
                   i, u_if.coin_sel, u_if.change_left, 2'(code_of(v)), rem);
        end
        d = $urandom_range(0, max_dly);
        for (int k = 0; k < d; k++) begin
          step();
          total++;
          if (u_if.coin_req !== 1'b1 || u_if.coin_sel !== 2'(code_of(v))) begin
            bad++;
            $display("FAIL req_hold: got req=%b sel=%b want req=1 sel=%b",
                     u_if.coin_req, u_if.coin_sel, 2'(code_of(v)));
          end
        end
        u_if.coin_ack = 1'b1;
        step();
        rem -= v;
`ifdef COIN_INVENTORY_EN
        if (v == 10) m_cnt10--;
        if (v == 5) m_cnt5--;
`endif
        // stray ack and start during the gap must not count
        u_if.coin_ack = noise;
        if (noise) begin
          u_if.start = 1'b1;
          u_if.paid  = 8'($urandom_range(0, 255));
          u_if.price = 8'd0;
        end
        total++;
        if (u_if.coin_req !== 1'b0 || u_if.coin_sel !== 2'b00 || u_if.change_left !== 8'(rem)) begin
          bad++;
          $display("FAIL after_ack%0d: got req=%b sel=%b left=%0d want req=0 sel=00 left=%0d",
                   i, u_if.coin_req, u_if.coin_sel, u_if.change_left, rem);
        end
        step();
        u_if.coin_ack = 1'b0;
        u_if.start    = 1'b0;
      end
      cnt = 0;
      while (u_if.done !== 1'b1 && cnt < 20) begin
        total++;
        if (u_if.coin_req !== 1'b0) begin
          bad++;
          $display("FAIL extra_coin: got coin_req=1 want 0 after %0d coins", ncoins);
        end
        step();
        cnt++;
      end
      total++;
      if (u_if.done !== 1'b1 || u_if.change_left !== 8'd0) begin
        bad++;
        $display("FAIL done: got done=%b left=%0d want done=1 left=0", u_if.done, u_if.change_left);
      end
    end
    step();
    total++;
    if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL post_done: got done=%b busy=%b want 0 0", u_if.done, u_if.busy);
    end
    m_left = 0;
    $display("txn dispense paid=%0d price=%0d change=%0d coins=%0d", paid, price, ch, ncoins);
  endtask

  task automatic test_underpay(input int paid, input int price);
    u_if.start = 1'b1;
    u_if.paid  = 8'(paid);
    u_if.price = 8'(price);
    step();
    u_if.start = 1'b0;
    total++;
    if (u_if.err_underpay !== 1'b1 || u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL underpay_pulse: got err=%b busy=%b want err=1 busy=0", u_if.err_underpay, u_if.busy);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (u_if.err_underpay !== 1'b0 || u_if.coin_req !== 1'b0 || u_if.busy !== 1'b0 ||
          u_if.change_left !== 8'(m_left)) begin
        bad++;
        $display("FAIL underpay_idle: got err=%b req=%b busy=%b left=%0d want 0 0 0 %0d",
                 u_if.err_underpay, u_if.coin_req, u_if.busy, u_if.change_left, m_left);
      end
    end
    $display("txn underpay paid=%0d price=%0d", paid, price);
  endtask

  task automatic test_timeout();
    u_if.start = 1'b1;
    u_if.paid  = 8'd15;
    u_if.price = 8'd0;
    step();
    u_if.start = 1'b0;
    step();
    for (int k = 0; k < TB_ACK; k++) begin
      total++;
      if (u_if.coin_req !== 1'b1 || u_if.coin_sel !== 2'b11 || u_if.fault !== 1'b0) begin
        bad++;
        $display("FAIL tmo_req%0d: got req=%b sel=%b fault=%b want 1 11 0",
                 k, u_if.coin_req, u_if.coin_sel, u_if.fault);
      end
      step();
    end
    total++;
    if (u_if.fault !== 1'b1 || u_if.coin_req !== 1'b0 || u_if.change_left !== 8'd15 || u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_fault: got fault=%b req=%b left=%0d busy=%b want 1 0 15 0",
               u_if.fault, u_if.coin_req, u_if.change_left, u_if.busy);
    end
    u_if.start    = 1'b1;
    u_if.paid     = 8'd50;
    u_if.coin_ack = 1'b1;
    step();
    u_if.start    = 1'b0;
    u_if.coin_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (u_if.fault !== 1'b1 || u_if.coin_req !== 1'b0 || u_if.change_left !== 8'd15 || u_if.busy !== 1'b0) begin
        bad++;
        $display("FAIL fault_sticky: got fault=%b req=%b left=%0d busy=%b want 1 0 15 0",
                 u_if.fault, u_if.coin_req, u_if.change_left, u_if.busy);
      end
    end
    reset = 1'b0;
    step();
    check_all_zero("fault_reset");
    reset = 1'b1;
    model_reload();
    m_left = 0;
    $display("txn timeout paid=15 price=0");
  endtask

  task automatic test_reset_mid();
    int cnt;
    u_if.start = 1'b1;
    u_if.paid  = 8'd30;
    u_if.price = 8'd3;
    step();
    u_if.start = 1'b0;
    step();
    u_if.coin_ack = 1'b1;
    step();
    u_if.coin_ack = 1'b0;
    cnt = 0;
    while (u_if.coin_req !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    total++;
    if (u_if.coin_req !== 1'b1 || u_if.change_left !== 8'd17) begin
      bad++;
      $display("FAIL second_req: got req=%b left=%0d want 1 17", u_if.coin_req, u_if.change_left);
    end
    reset = 1'b0;
    step();
    check_all_zero("reset_mid_coin");
    reset = 1'b1;
    model_reload();
    m_left = 0;
    $display("txn reset_mid paid=30 price=3");
    test_dispense(30, 3, 2, 1'b0);
  endtask

  task automatic test_random();
    int paid;
    int price;
    for (int n = 0; n < 16; n++) begin
      paid = $urandom_range(0, 255);
      if ($urandom_range(0, 4) == 0 && paid < 255) begin
        price = $urandom_range(paid + 1, 255);
        test_underpay(paid, price);
      end else begin
        price = $urandom_range(0, paid);
        test_dispense(paid, price, 3, 1'($urandom_range(0, 1)));
      end
    end
  endtask

`ifdef COIN_INVENTORY_EN
  task automatic test_inventory();
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_reload();
    test_dispense(25, 0, 1, 1'b0);
    u_if.refill = 1'b1;
    step();
    u_if.refill = 1'b0;
    model_reload();
    test_dispense(25, 0, 1, 1'b0);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    model_reload();
    m_left = 0;
    reset         = 1'b0;
    u_if.start    = 1'b0;
    u_if.paid     = 8'd0;
    u_if.price    = 8'd0;
    u_if.coin_ack = 1'b0;
`ifdef COIN_INVENTORY_EN
    u_if.refill   = 1'b0;
`endif
    test_reset();
    test_dispense(20, 6, 1, 1'b0);
    test_underpay(5, 10);
    test_dispense(6, 6, 0, 1'b0);
    test_timeout();
    test_reset_mid();
    test_dispense(40, 0, 2, 1'b1);
`ifdef COIN_INVENTORY_EN
    test_inventory();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute guard against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the vending-machine controller.
- Once payment is accepted (dispatch state), the controller pulses start with the entered amount and the total price.
- The block computes change = paid - price and drives the coin-hopper mechanism one coin at a time, largest denomination first ($10, $5, $1).
- A coin request is held until the hopper acknowledges it. The remaining change is exported for the seven-segment display path.

Parameters:
- ACK_TIMEOUT, 255: max cycles coin_req may wait for coin_ack before entering FAULT; range 1..255.
- GAP_CYCLES, 4: idle cycles with coin_req low between consecutive coins; range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle pulse from the controller; sampled only in IDLE.
- paid  in  8  entered amount, binary dollars; sampled with start.
- price  in  8  total price, binary dollars; sampled with start.
- coin_ack  in  1  hopper has released the requested coin; honoured only in REQ.
- coin_req  out  1  registered; high while a coin request is outstanding.
- coin_sel  out  2  registered denomination code: 00 none, 01 $1, 10 $5, 11 $10; stable while coin_req is high.
- change_left  out  8  remaining change to dispense (binary, feeds binary2bcd).
- busy  out  1  high in every state except IDLE and FAULT.
- done  out  1  one-cycle pulse when change is fully dispensed.
- err_underpay  out  1  one-cycle pulse when start arrives with paid < price.
- fault  out  1  sticky hopper-timeout flag.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; all outputs 0; internal counters 0. Reset applies in any state, mid-coin included. An outstanding coin_req drops on the next edge.
- IDLE:
  - start=1 and paid>=price: latch change_left=paid-price (8-bit unsigned, no overflow possible); go to SELECT.
  - start=1 and paid<price: err_underpay=1 for the next cycle; stay in IDLE; change_left unchanged.
  - start=0: hold.
- SELECT (one cycle):
  - change_left>=10 -> coin_sel=11; >=5 -> 10; >=1 -> 01; go to REQ.
  - change_left==0 -> go to DONE.
  - Result: zero change gives done two cycles after the start edge.
- REQ:
  - coin_req=1. Timeout counter starts at 0 on entry and increments each cycle.
  - coin_ack=1: subtract the coin value from change_left; clear coin_req and coin_sel; go to GAP. An ack in the first REQ cycle counts.
  - Counter reaching ACK_TIMEOUT without an ack: go to FAULT.
- Latency: coin_req rises two edges after the start edge (IDLE -> SELECT -> REQ).
- GAP: hold coin_req=0 for exactly GAP_CYCLES cycles, then go to SELECT.
- DONE: done=1 for one cycle; change_left=0; go to IDLE.
- FAULT:
  - fault=1, coin_req=0, busy=0.
  - change_left frozen at the undispensed amount.
  - start and coin_ack ignored. Exit only via reset.
- start while busy: ignored; no re-latch.
- coin_ack outside REQ: ignored.
- Coins per transaction are bounded: at most 25 $10 coins + 1 $5 + 4 $1.

Optional Feature:
- Macro: COIN_INVENTORY_EN.
- With the macro:
  - Adds input refill (1-bit pulse) and parameters TUBE10_INIT=20 and TUBE5_INIT=20.
  - Internal 8-bit counters cnt10 and cnt5 load their INIT values on reset or refill, and decrement on each acked coin of that denomination.
  - SELECT skips a denomination whose count is 0 and falls to the next smaller one. $1 is unlimited.
  - refill during REQ takes effect for the next SELECT.
- Without the macro: no refill port, no counters, unlimited coins of every denomination.

Decomposition:
- Package vend_pkg holds:
  - denomination codes (COIN_NONE, COIN_1, COIN_5, COIN_10) and their 8-bit values;
  - the state encoding (IDLE, SELECT, REQ, GAP, DONE, FAULT);
  - a function mapping a code to its value.
- Sub-module denom_picker: combinational. Takes change_left and (under COIN_INVENTORY_EN) the tube-empty flags; returns coin_sel and a zero flag. It is the natural unit to test exhaustively.

Test Plan:
- paid=20, price=6, coin_ack one cycle after each coin_req -> coin_sel sequence 11,01,01,01,01; change_left 14->4->3->2->1->0; done pulses once; busy low afterwards.
- paid=5, price=10 -> err_underpay pulses one cycle after start; coin_req never rises; state stays IDLE.
- paid=6, price=6 -> no coin_req; done pulses exactly 2 cycles after the start edge.
- paid=15, price=0, coin_ack held low, ACK_TIMEOUT=8 -> coin_req high with sel=11 for 8 cycles, then fault=1, coin_req=0, change_left=15; a new start is ignored until reset.
- paid=30, price=3, reset driven low during the second REQ -> next edge: all outputs 0, state IDLE; a fresh start then dispenses normally.
- COIN_INVENTORY_EN, TUBE10_INIT=1, paid=25, price=0 -> sequence 11,10,10,10; refill pulse then restores $10 use on the next transaction.
